param_frame_generator: RTL and testbench

PARAM_FRAME_GENERATOR -- requirements
Module: param_frame_generator

---
 rtl/param_frame_generator.sv | 162 ++++++++++++++++
 tb/tb_param_frame_generator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/param_frame_generator.sv
// Frame generator: sync word, NUM_WORDS payload words and, when PFG_CHECKSUM_EN is defined,
// a checksum trailer, each emitted as a registered {tag, data} word with flow-control pause.
module param_frame_generator #(
  parameter int                DATA_W     = 8,
  parameter int                NUM_WORDS  = 16,
  parameter logic [DATA_W-1:0] SYNC_WORD  = DATA_W'(8'hA5),
  parameter bit                CONTINUOUS = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic                        flow_control_enable,
  input  logic [NUM_WORDS*DATA_W-1:0] frame_data_in,
  output logic [DATA_W+1:0]           frame_data_with_sync,
  output logic                        frame_valid,
  output logic                        busy,
  output logic                        frame_done
);
  localparam int               IDX_W    = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [1:0]       TAG_SYNC = 2'b10;
  localparam logic [1:0]       TAG_DATA = 2'b01;
`ifdef PFG_CHECKSUM_EN
  localparam logic [1:0]       TAG_CSUM = 2'b11;
  localparam bit               CSUM_EN  = 1'b1;
`else
  localparam bit               CSUM_EN  = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
`ifdef PFG_CHECKSUM_EN
    CSUM = 2'd3,
`endif
    DATA = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            index_q, index_d;
  logic                        held_q, held_d;
  logic [NUM_WORDS*DATA_W-1:0] payload_q, payload_d;
  logic [DATA_W+1:0]           word_q, word_d;
  logic                        valid_q;
  logic                        done_q, done_d;
  logic                        capture;
  logic [IDX_W-1:0]            index_adv;
  logic [DATA_W-1:0]           next_word;
  logic [DATA_W-1:0]           words [NUM_WORDS];
`ifdef PFG_CHECKSUM_EN
  logic [DATA_W-1:0]           csum_q, csum_d;
`endif

  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_unpack
    assign words[gi] = payload_q[gi*DATA_W +: DATA_W];
  end

  // state/index name the word currently shown; held_q marks a sync captured under pause, not yet shown
  assign index_adv = (state_q == SYNC) ? '0 : index_q + 1'b1;
  assign next_word = words[index_adv];

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    held_d    = held_q;
    payload_d = payload_q;
    word_d    = '0;
    done_d    = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: capture = start;
      SYNC: if (!flow_control_enable) begin
        if (held_q) begin
          held_d = 1'b0;
          word_d = {TAG_SYNC, SYNC_WORD};
        end else begin
          state_d = DATA;
          index_d = index_adv;
          word_d  = {TAG_DATA, next_word};
        end
      end
      DATA: if (!flow_control_enable) begin
        if (index_q != LAST_IDX) begin
          index_d = index_adv;
          word_d  = {TAG_DATA, next_word};
          done_d  = !CSUM_EN && (index_adv == LAST_IDX);
        end else begin
`ifdef PFG_CHECKSUM_EN
          state_d = CSUM;
          word_d  = {TAG_CSUM, csum_q};
          done_d  = 1'b1;
`else
          capture = CONTINUOUS;
          if (!CONTINUOUS) begin
            state_d = IDLE;
            index_d = '0;
          end
`endif
        end
      end
`ifdef PFG_CHECKSUM_EN
      CSUM: if (!flow_control_enable) begin
        capture = CONTINUOUS;
        if (!CONTINUOUS) begin
          state_d = IDLE;
          index_d = '0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (capture) begin
      payload_d = frame_data_in;
      state_d   = SYNC;
      index_d   = '0;
      if (flow_control_enable) held_d = 1'b1;
      else                     word_d = {TAG_SYNC, SYNC_WORD};
    end
  end

`ifdef PFG_CHECKSUM_EN
  // Capture and payload emission never coincide, so one priority chain covers both.
  always_comb begin
    csum_d = csum_q;
    if (capture)                                    csum_d = '0;
    else if (word_d[DATA_W+1:DATA_W] == TAG_DATA)   csum_d = csum_q + word_d[DATA_W-1:0];
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      index_q <= '0;
      held_q  <= 1'b0;
      word_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef PFG_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      held_q  <= held_d;
      word_q  <= word_d;
      valid_q <= |word_d[DATA_W+1:DATA_W];
      done_q  <= done_d;
`ifdef PFG_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    payload_q <= payload_d;
  end

  assign frame_data_with_sync = word_q;
  assign frame_valid          = valid_q;
  assign frame_done           = done_q;
  assign busy                 = (state_q != IDLE);
endmodule

// File: tb/tb_param_frame_generator.sv
// Bench for param_frame_generator: a default instance and a continuous 16-bit/4-word instance,
// both checked each cycle against a queue-of-frame-words reference model.
module tb_param_frame_generator;
  logic        clk = 1'b0;
  logic        reset_n, start, flow;
  logic [7:0]  pay_a [16];
  logic [15:0] pay_b [4];
  logic [127:0] din_a;
  logic [63:0]  din_b;
  logic [9:0]  out_a;
  logic [17:0] out_b;
  logic        valid_a, busy_a, done_a, valid_b, busy_b, done_b;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          frames_a = 0;

  for (genvar gi = 0; gi < 16; gi++) begin : g_din_a
    assign din_a[gi*8 +: 8] = pay_a[gi];
  end
  for (genvar gi = 0; gi < 4; gi++) begin : g_din_b
    assign din_b[gi*16 +: 16] = pay_b[gi];
  end

  always #5 clk = ~clk;

  param_frame_generator u_def (
    .clk(clk), .reset_n(reset_n), .start(start), .flow_control_enable(flow),
    .frame_data_in(din_a), .frame_data_with_sync(out_a), .frame_valid(valid_a),
    .busy(busy_a), .frame_done(done_a)
  );

  param_frame_generator #(
    .DATA_W(16), .NUM_WORDS(4), .SYNC_WORD(16'h00A5), .CONTINUOUS(1'b1)
  ) u_cont (
    .clk(clk), .reset_n(reset_n), .start(start), .flow_control_enable(flow),
    .frame_data_in(din_b), .frame_data_with_sync(out_b), .frame_valid(valid_b),
    .busy(busy_b), .frame_done(done_b)
  );

  // Reference model: a frame is a list of words; each unpaused edge hands out the next one.
  logic [63:0] qa[$];
  logic [63:0] qb[$];
  bit          act_a, act_b;
  logic [63:0] exp_word [2];
  bit          exp_done [2];
  bit          exp_busy [2];

  function automatic logic [63:0] word_of(input int id, input int k);
    if (id == 0) return 64'(pay_a[k]);
    return 64'(pay_b[k]);
  endfunction

  task automatic model_edge(input int id);
    logic [63:0] q[$];
    bit          act, cap;
    int          dw, nw;
    logic [63:0] mask, sum, w;
    dw   = (id == 0) ? 8 : 16;
    nw   = (id == 0) ? 16 : 4;
    mask = (64'd1 << dw) - 64'd1;
    if (id == 0) begin q = qa; act = act_a; end
    else         begin q = qb; act = act_b; end
    exp_word[id] = '0;
    exp_done[id] = 1'b0;
    if (!reset_n) begin
      q.delete();
      act = 1'b0;
    end else begin
      cap = (!act && start) || (act && q.size() == 0 && !flow && id == 1);
      if (cap) begin
        q.delete();
        sum = '0;
        q.push_back((64'd2 << dw) | 64'hA5);
        for (int k = 0; k < nw; k++) begin
          w   = word_of(id, k) & mask;
          sum = (sum + w) & mask;
          q.push_back((64'd1 << dw) | w);
        end
`ifdef PFG_CHECKSUM_EN
        q.push_back((64'd3 << dw) | sum);
`endif
        act = 1'b1;
      end else if (act && q.size() == 0 && !flow) begin
        act = 1'b0;
      end
      if (act && q.size() > 0 && !flow) begin
        exp_word[id] = q.pop_front();
        exp_done[id] = (q.size() == 0);
      end
    end
    exp_busy[id] = act;
    if (id == 0) begin qa = q; act_a = act; end
    else         begin qb = q; act_b = act; end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all(input string pfx);
    check({pfx, ".a_word"},  64'(out_a),   exp_word[0]);
    check({pfx, ".a_valid"}, 64'(valid_a), 64'((exp_word[0] >> 8) != 0));
    check({pfx, ".a_busy"},  64'(busy_a),  64'(exp_busy[0]));
    check({pfx, ".a_done"},  64'(done_a),  64'(exp_done[0]));
    check({pfx, ".b_word"},  64'(out_b),   exp_word[1]);
    check({pfx, ".b_valid"}, 64'(valid_b), 64'((exp_word[1] >> 16) != 0));
    check({pfx, ".b_busy"},  64'(busy_b),  64'(exp_busy[1]));
    check({pfx, ".b_done"},  64'(done_b),  64'(exp_done[1]));
    if (exp_done[0]) begin
      frames_a++;
      $display("[TB] frame %0d on default instance ended with word %0h at %0t", frames_a, out_a, $time);
    end
  endtask

  task automatic cycle(input string pfx);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    compare_all(pfx);
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    model_edge(0);
    model_edge(1);
    compare_all("rst_async");
    cycle("rst_held");
    reset_n = 1'b1;
  endtask

  task automatic run(input string pfx, input int n);
    for (int i = 0; i < n; i++) cycle(pfx);
  endtask

  initial begin
    logic [7:0] sum8;
    reset_n = 1'b1;
    start   = 1'b0;
    flow    = 1'b0;
    pay_a   = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h01, 8'h02,
                8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    pay_b   = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    #3 reset_n = 1'b0;
    #1;
    model_edge(0);
    model_edge(1);
    compare_all("reset");
    cycle("reset_held");
    reset_n = 1'b1;

    // Basic frame with the reference payload
    start = 1'b1;
    cycle("basic");
    start = 1'b0;
    check("basic.sync", 64'(out_a), 64'h2A5);
    run("basic", 16);
    check("basic.last", 64'(out_a), 64'h10A);
    sum8 = '0;
    foreach (pay_a[k]) sum8 += pay_a[k];
`ifdef PFG_CHECKSUM_EN
    cycle("basic");
    check("basic.csum", 64'(out_a), {54'd0, 2'b11, sum8});
    check("basic.csum_done", 64'(done_a), 64'd1);
`else
    check("basic.last_done", 64'(done_a), 64'd1);
`endif
    cycle("basic");
    check("basic.idle", 64'(out_a), 64'h000);
    run("basic", 3);

    // Five-cycle pause holding the fourth payload word
    start = 1'b1;
    cycle("pause");
    start = 1'b0;
    run("pause", 3);
    flow = 1'b1;
    run("pause", 5);
    flow = 1'b0;
    cycle("pause");
    check("pause.resume", 64'(out_a), 64'h1DD);
    run("pause", 16);

    // start pulses while busy are ignored
    start = 1'b1;
    cycle("busy_start");
    start = 1'b0;
    run("busy_start", 2);
    start = 1'b1;
    cycle("busy_start");
    start = 1'b0;
    run("busy_start", 6);
    start = 1'b1;
    cycle("busy_start");
    start = 1'b0;
    run("busy_start", 12);

    // Reset mid-frame, then restart on the first edge after release
    start = 1'b1;
    cycle("midrst");
    start = 1'b0;
    run("midrst", 8);
    async_reset();
    start = 1'b1;
    cycle("restart");
    start = 1'b0;
    check("restart.sync", 64'(out_a), 64'h2A5);
    check("restart.sync_b", 64'(out_b), 64'h200A5);
    run("restart", 3);
    pay_b = '{16'hBEEF, 16'hCAFE, 16'hF00D, 16'h1234};
    run("restart", 18);

    // start together with pause in IDLE: captured, sync held
    start = 1'b1;
    flow  = 1'b1;
    cycle("startpause");
    start = 1'b0;
    check("startpause.busy", 64'(busy_a), 64'd1);
    cycle("startpause");
    flow = 1'b0;
    cycle("startpause");
    check("startpause.sync", 64'(out_a), 64'h2A5);
    run("startpause", 20);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 7) == 0);
      flow  = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) begin
        pay_a[$urandom_range(0, 15)] = 8'($urandom);
        pay_b[$urandom_range(0, 3)]  = 16'($urandom);
      end
      if ($urandom_range(0, 199) == 0) async_reset();
      else                             cycle("random");
    end
    start = 1'b0;
    flow  = 1'b0;
    run("drain", 25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
